render_window_compositor: RTL and testbench
===========================================

// Module: render_window_compositor
// PURPOSE
// - Sits between the ray renderer pixel stream and VGA scan-out; successor to the fixed 12-bit window buffer.
// - Stores renderer pixels for a parametrised screen window.
// - Composites them over a background colour and outputs scan-out pixels and syncs, all delay-matched.
// - Generalised in window geometry and channel depth; adds frame-complete tracking and tear-free bank swapping.
// PARAMETERS
// - START_X   390        window left edge (hcount units, inclusive)
// - START_Y   390        window top edge (vcount units, inclusive)
// - WIN_W     244        window width in pixels; END_X = START_X+WIN_W (exclusive)
// - WIN_H     375        window height in lines; END_Y = START_Y+WIN_H (exclusive)
// - CH_BITS   4          stored/output bits per channel; taken from MSBs of each 8-bit input channel
// - BG_COLOR  12'h000    colour for active-draw pixels outside window; width 3*CH_BITS
// PORTS
// - aclk          in   1        single clock for write and scan-out sides
// - aresetn       in   1        asynchronous active-low reset
// - wr_hcount_in  in   11       renderer pixel x
// - wr_vcount_in  in   10       renderer pixel y
// - wr_pixel_in   in   24       renderer RGB888 {R,G,B}
// - wr_valid_in   in   1        renderer pixel valid
// - wr_ready_out  out  1        compositor can accept a pixel
// - frame_done_out out 1        1-cycle pulse when pixel (END_X-1, END_Y-1) is accepted
// - hcount_in     in   11       scan-out x from vga_sig_gen
// - vcount_in     in   10       scan-out y
// - hs_in         in   1        scan-out hsync
// - vs_in         in   1        scan-out vsync
// - ad_in         in   1        active draw
// - nf_in         in   1        new-frame pulse
// - hs_out        out  1        hs_in delayed 2 cycles
// - vs_out        out  1        vs_in delayed 2 cycles
// - pixel_out     out  3*CH_BITS  composited {R,G,B}, aligned with hs_out/vs_out
// BEHAVIOUR
// - Reset (async): hs_out=vs_out=0, pixel_out=0, frame_done_out=0, wr_ready_out=1.
// - Reset also sets front bank=0 and clears bank_full. RAM contents are not cleared.
// - Write accept:
//   - accept = wr_valid_in & wr_ready_out.
//   - A pixel outside the window is accepted and discarded.
//   - Otherwise it is written at addr=(x-START_X)+(y-START_Y)*WIN_W in the back bank, 1-cycle write.
// - Frame complete:
//   - Accepting in-window pixel (END_X-1,END_Y-1) pulses frame_done_out on the next cycle.
//   - It also sets bank_full.
// - Read side:
//   - Address registered from hcount_in/vcount_in; front-bank read has 2-cycle total latency.
//   - in_window, ad_in, hs_in and vs_in are piped 2 stages.
//   - pixel_out = !ad_d2 ? 0 : (!in_window_d2 ? BG_COLOR : ram_dout).
// - Arithmetic: address math is unsigned. Window compare happens before subtraction, so there is no wrap.
// - Depth = WIN_W*WIN_H per bank.
// - Simultaneous events:
//   - Last-pixel accept in the same cycle as nf_in: bank_full is set, no swap that cycle; the swap waits for the next nf_in.
//   - Write and read at the same address (single-bank mode): read-first, so the old data is output.
// - Reset mid-frame: flags cleared, the partially written back bank is reused and overwritten by the next frame.
// CONFIGURATION
// - Macro: RENDER_WINDOW_DOUBLE_BUFFER_EN.
// - Defined:
//   - Two banks; the scan-out reads the front bank, the renderer writes the back bank.
//   - wr_ready_out=0 while bank_full=1.
//   - On nf_in with bank_full=1: front bank toggles, bank_full clears, and wr_ready_out returns to 1 on the next cycle.
// - Undefined:
//   - One bank; wr_ready_out is constant 1 and bank_full is ignored.
//   - frame_done_out still pulses. Tearing is permitted.
// TESTING (START_X=10, START_Y=5, WIN_W=4, WIN_H=2, CH_BITS=4, BG_COLOR=12'h00F)
// - Reset: hold aresetn=0 with random inputs -> outputs 0 and wr_ready_out=1; release -> no spurious frame_done_out.
// - Write in-window pixel (11,5)=24'hA0B0C0, then scan (11,5) with ad_in=1 -> pixel_out=12'hABC exactly 2 cycles later.
// - Scan (9,5) with ad_in=1 -> 12'h00F; scan with ad_in=0 -> 12'h000. hs/vs edges are delayed exactly 2 cycles.
// - Write (20,20) then scan the window -> all window contents unchanged; pixel still accepted (ready stays 1).
// - Double buffer: fill all 8 pixels with 24'hFF0000 -> frame_done_out pulse, ready=0.
//   - Scan still shows the old bank. nf_in -> ready=1 next cycle; scan shows 12'hF00.
// - Double buffer: last pixel and nf_in in the same cycle -> no swap. Next nf_in -> swap.
//   - Assert aresetn=0 mid-fill -> ready=1, front bank=0.

Source files
------------

// File: rtl/render_window_compositor.sv
// Window pixel store and scan-out compositor between the ray renderer and VGA timing.
// Define RENDER_WINDOW_DOUBLE_BUFFER_EN for two banks with a tear-free swap on nf_in.
module render_window_compositor #(
    parameter int START_X  = 390,
    parameter int START_Y  = 390,
    parameter int WIN_W    = 244,
    parameter int WIN_H    = 375,
    parameter int CH_BITS  = 4,
    parameter logic [3*CH_BITS-1:0] BG_COLOR = 12'h000
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [10:0]            wr_hcount_in,
    input  logic [9:0]             wr_vcount_in,
    input  logic [23:0]            wr_pixel_in,
    input  logic                   wr_valid_in,
    output logic                   wr_ready_out,
    output logic                   frame_done_out,
    input  logic [10:0]            hcount_in,
    input  logic [9:0]             vcount_in,
    input  logic                   hs_in,
    input  logic                   vs_in,
    input  logic                   ad_in,
    input  logic                   nf_in,
    output logic                   hs_out,
    output logic                   vs_out,
    output logic [3*CH_BITS-1:0]   pixel_out
);
    localparam int END_X = START_X + WIN_W;
    localparam int END_Y = START_Y + WIN_H;
    localparam int DEPTH = WIN_W * WIN_H;
`ifdef RENDER_WINDOW_DOUBLE_BUFFER_EN
    localparam int BANKS = 2;
`else
    localparam int BANKS = 1;
`endif
    localparam int RAM_DEPTH = BANKS * DEPTH;
    localparam int RAM_AW    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int PIX_W     = 3 * CH_BITS;

    function automatic logic in_window(input logic [10:0] x, input logic [9:0] y);
        return (int'(x) >= START_X) && (int'(x) < END_X) &&
               (int'(y) >= START_Y) && (int'(y) < END_Y);
    endfunction

    // Only called for in-window coordinates, so the subtractions never go negative.
    function automatic logic [RAM_AW-1:0] ram_index(input logic [10:0] x, input logic [9:0] y,
                                                    input logic bank);
        int lin;
        lin = (int'(x) - START_X) + (int'(y) - START_Y) * WIN_W + (bank ? DEPTH : 0);
        return lin[RAM_AW-1:0];
    endfunction

    logic              wr_bank;
    logic              rd_bank;
    logic              wr_in_win;
    logic              wr_accept;
    logic              wr_en;
    logic              last_accept;
    logic [RAM_AW-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_pix_trunc;
    logic              unused_inputs;

    // Keep the top CH_BITS of each 8-bit channel, preserving {R,G,B} order.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_ch
            assign wr_pix_trunc[gi*CH_BITS +: CH_BITS] = wr_pixel_in[gi*8 + 8 - CH_BITS +: CH_BITS];
        end
    endgenerate

    assign unused_inputs = ^{wr_pixel_in, nf_in};

    assign wr_accept   = wr_valid_in & wr_ready_out;
    assign wr_in_win   = in_window(wr_hcount_in, wr_vcount_in);
    assign wr_en       = wr_accept & wr_in_win;
    assign wr_addr     = wr_in_win ? ram_index(wr_hcount_in, wr_vcount_in, wr_bank) : '0;
    assign last_accept = wr_en && (int'(wr_hcount_in) == END_X - 1) &&
                         (int'(wr_vcount_in) == END_Y - 1);

`ifdef RENDER_WINDOW_DOUBLE_BUFFER_EN
    logic front_reg;
    logic bank_full_reg;

    // A swap only consumes an already-full bank; a frame finishing on the nf_in cycle waits.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            front_reg     <= 1'b0;
            bank_full_reg <= 1'b0;
        end else if (nf_in && bank_full_reg) begin
            front_reg     <= ~front_reg;
            bank_full_reg <= 1'b0;
        end else if (last_accept) begin
            bank_full_reg <= 1'b1;
        end
    end

    assign wr_ready_out = ~bank_full_reg;
    assign wr_bank      = ~front_reg;
    assign rd_bank      = front_reg;
`else
    assign wr_ready_out = 1'b1;
    assign wr_bank      = 1'b0;
    assign rd_bank      = 1'b0;
`endif

    logic [PIX_W-1:0]  mem [0:RAM_DEPTH-1];
    logic [RAM_AW-1:0] rd_addr_reg;
    logic [PIX_W-1:0]  ram_dout_reg;

    // Read-first: a same-edge write to the read address returns the old word.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_pix_trunc;
        end
        ram_dout_reg <= mem[rd_addr_reg];
    end

    logic rd_in_win;
    logic in_win_d1_reg, in_win_d2_reg;
    logic ad_d1_reg, ad_d2_reg;
    logic hs_d1_reg, hs_d2_reg;
    logic vs_d1_reg, vs_d2_reg;
    logic frame_done_reg;

    assign rd_in_win = in_window(hcount_in, vcount_in);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_addr_reg    <= '0;
            in_win_d1_reg  <= 1'b0;
            in_win_d2_reg  <= 1'b0;
            ad_d1_reg      <= 1'b0;
            ad_d2_reg      <= 1'b0;
            hs_d1_reg      <= 1'b0;
            hs_d2_reg      <= 1'b0;
            vs_d1_reg      <= 1'b0;
            vs_d2_reg      <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            rd_addr_reg    <= rd_in_win ? ram_index(hcount_in, vcount_in, rd_bank) : '0;
            in_win_d1_reg  <= rd_in_win;
            in_win_d2_reg  <= in_win_d1_reg;
            ad_d1_reg      <= ad_in;
            ad_d2_reg      <= ad_d1_reg;
            hs_d1_reg      <= hs_in;
            hs_d2_reg      <= hs_d1_reg;
            vs_d1_reg      <= vs_in;
            vs_d2_reg      <= vs_d1_reg;
            frame_done_reg <= last_accept;
        end
    end

    always_comb begin
        pixel_out = '0;
        if (ad_d2_reg) begin
            pixel_out = in_win_d2_reg ? ram_dout_reg : BG_COLOR;
        end
    end

    assign hs_out         = hs_d2_reg;
    assign vs_out         = vs_d2_reg;
    assign frame_done_out = frame_done_reg;
endmodule

// File: tb/tb_render_window_compositor.sv
// Directed bench for render_window_compositor with a frame-level model checked every cycle.
module tb_render_window_compositor;
    localparam int SX = 10;
    localparam int SY = 5;
    localparam int WW = 4;
    localparam int WH = 2;
`ifdef RENDER_WINDOW_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [10:0] wr_hcount_in = '0;
    logic [9:0]  wr_vcount_in = '0;
    logic [23:0] wr_pixel_in = '0;
    logic        wr_valid_in = 1'b0;
    logic        wr_ready_out;
    logic        frame_done_out;
    logic [10:0] hcount_in = '0;
    logic [9:0]  vcount_in = '0;
    logic        hs_in = 1'b0, vs_in = 1'b0, ad_in = 1'b0, nf_in = 1'b0;
    logic        hs_out, vs_out;
    logic [11:0] pixel_out;

    render_window_compositor #(
        .START_X(SX), .START_Y(SY), .WIN_W(WW), .WIN_H(WH), .CH_BITS(4), .BG_COLOR(12'h00F)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .wr_hcount_in(wr_hcount_in), .wr_vcount_in(wr_vcount_in), .wr_pixel_in(wr_pixel_in),
        .wr_valid_in(wr_valid_in), .wr_ready_out(wr_ready_out), .frame_done_out(frame_done_out),
        .hcount_in(hcount_in), .vcount_in(vcount_in), .hs_in(hs_in), .vs_in(vs_in),
        .ad_in(ad_in), .nf_in(nf_in), .hs_out(hs_out), .vs_out(vs_out), .pixel_out(pixel_out)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit win(input int x, input int y);
        return x >= SX && x < SX + WW && y >= SY && y < SY + WH;
    endfunction

    function automatic logic [11:0] trunc(input logic [23:0] p);
        return {p[23:20], p[15:12], p[7:4]};
    endfunction

    // Model: two frame stores, which one is on screen, and whether the back one is complete.
    logic [11:0] mem_m [2][8];
    bit          known_m [2][8];
    bit          front_m, full_m, fd_exp;
    logic [11:0] st_pix, out_pix;
    bit          st_known, st_hs, st_vs, out_known, out_hs, out_vs;

    always @(posedge aclk) begin : model
        bit f_old, acc;
        int idx, b;
        if (!aresetn) begin
            front_m = 0; full_m = 0; fd_exp = 0;
            st_pix = '0; st_known = 1; st_hs = 0; st_vs = 0;
            out_pix = '0; out_known = 1; out_hs = 0; out_vs = 0;
        end else begin
            f_old = front_m;
            out_pix = st_pix; out_known = st_known; out_hs = st_hs; out_vs = st_vs;
            acc = wr_valid_in && !(DB && full_m);
            fd_exp = 0;
            if (acc && win(int'(wr_hcount_in), int'(wr_vcount_in))) begin
                idx = (int'(wr_hcount_in) - SX) + (int'(wr_vcount_in) - SY) * WW;
                b = DB ? int'(!f_old) : 0;
                mem_m[b][idx] = trunc(wr_pixel_in);
                known_m[b][idx] = 1;
                fd_exp = (int'(wr_hcount_in) == SX + WW - 1) && (int'(wr_vcount_in) == SY + WH - 1);
            end
            if (DB && nf_in && full_m) begin
                front_m = !front_m;
                full_m = 0;
            end else if (DB && fd_exp) begin
                full_m = 1;
            end
            st_hs = hs_in; st_vs = vs_in; st_known = 1;
            if (!ad_in) st_pix = '0;
            else if (!win(int'(hcount_in), int'(vcount_in))) st_pix = 12'h00F;
            else begin
                idx = (int'(hcount_in) - SX) + (int'(vcount_in) - SY) * WW;
                b = int'(f_old);
                st_pix = mem_m[b][idx];
                st_known = known_m[b][idx];
            end
        end
    end

    always @(negedge aclk) begin : compare
        if (!aresetn) begin
            chk("rst_hs_out", hs_out, 0);
            chk("rst_vs_out", vs_out, 0);
            chk("rst_pixel_out", pixel_out, 0);
            chk("rst_frame_done", frame_done_out, 0);
            chk("rst_wr_ready", wr_ready_out, 1);
        end else begin
            chk("hs_out", hs_out, out_hs);
            chk("vs_out", vs_out, out_vs);
            if (out_known) chk("pixel_out", pixel_out, out_pix);
            chk("frame_done", frame_done_out, fd_exp);
            chk("wr_ready", wr_ready_out, DB ? !full_m : 1'b1);
        end
    end

    // One clock of stimulus, applied just after a rising edge and held until the next one.
    task automatic cyc(input bit wv, input int wx, input int wy, input logic [23:0] wp,
                       input bit sad, input int sx, input int sy,
                       input bit hs, input bit vs, input bit nf);
        wr_valid_in = wv; wr_hcount_in = 11'(wx); wr_vcount_in = 10'(wy); wr_pixel_in = wp;
        ad_in = sad; hcount_in = 11'(sx); vcount_in = 10'(sy);
        hs_in = hs; vs_in = vs; nf_in = nf;
        @(posedge aclk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 24'h0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int x, input int y, input logic [23:0] p);
        $display("write (%0d,%0d) = %h", x, y, p);
        cyc(1, x, y, p, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic sc(input int x, input int y, input bit ad);
        $display("scan  (%0d,%0d) ad=%0b", x, y, ad);
        cyc(0, 0, 0, 24'h0, ad, x, y, 0, 0, 0);
    endtask

    task automatic nf();
        $display("new frame");
        cyc(0, 0, 0, 24'h0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic fill(input logic [23:0] base, input bit vary, input bit nf_last);
        for (int i = 0; i < 8; i++) begin
            logic [23:0] p;
            p = vary ? base + 24'(i) * 24'h101010 : base;
            $display("fill  (%0d,%0d) = %h nf=%0b", SX + i % 4, SY + i / 4, p, (i == 7) && nf_last);
            cyc(1, SX + i % 4, SY + i / 4, p, 0, 0, 0, 0, 0, (i == 7) && nf_last);
        end
    endtask

    task automatic scan_all();
        for (int i = 0; i < 8; i++) sc(SX + i % 4, SY + i / 4, 1);
        idle();
        idle();
    endtask

    initial begin : stimulus
        repeat (4) begin
            @(posedge aclk);
            #1;
            wr_valid_in = 1'($urandom); wr_hcount_in = 11'($urandom); wr_vcount_in = 10'($urandom);
            wr_pixel_in = 24'($urandom); hcount_in = 11'($urandom); vcount_in = 10'($urandom);
            hs_in = 1'($urandom); vs_in = 1'($urandom); ad_in = 1'($urandom); nf_in = 1'($urandom);
        end
        chk("reset_pixel", pixel_out, 12'h000);
        chk("reset_ready", wr_ready_out, 1);
        chk("reset_hs", hs_out, 0);
        wr_valid_in = 0; ad_in = 0; hs_in = 0; vs_in = 0; nf_in = 0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        repeat (3) idle();
        chk("post_reset_frame_done", frame_done_out, 0);

        // Background, blanking and sync delay.
        cyc(0, 0, 0, 24'h0, 1, 9, 5, 1, 0, 0);
        chk("hs_not_yet", hs_out, 0);
        cyc(0, 0, 0, 24'h0, 0, 11, 5, 0, 1, 0);
        chk("hs_two_cycles", hs_out, 1);
        chk("bg_pixel", pixel_out, 12'h00F);
        idle();
        chk("blank_pixel", pixel_out, 12'h000);
        chk("vs_two_cycles", vs_out, 1);
        chk("hs_fall", hs_out, 0);
        idle();
        chk("vs_fall", vs_out, 0);

        wr(20, 20, 24'h123456);
        chk("oob_ready", wr_ready_out, 1);
        chk("oob_no_done", frame_done_out, 0);

`ifndef RENDER_WINDOW_DOUBLE_BUFFER_EN
        wr(11, 5, 24'hA0B0C0);
        sc(11, 5, 1);
        chk("latency_early", pixel_out, 12'h000);
        idle();
        chk("latency_2cyc", pixel_out, 12'hABC);

        fill(24'h102030, 1, 0);
        chk("frame_done_pulse", frame_done_out, 1);
        chk("single_ready", wr_ready_out, 1);
        idle();
        chk("frame_done_clear", frame_done_out, 0);
        wr(20, 20, 24'hFFFFFF);
        scan_all();

        sc(10, 5, 1);
        wr(10, 5, 24'hF0E0D0);
        chk("read_first_old", pixel_out, 12'h123);
        idle();
        sc(10, 5, 1);
        idle();
        chk("read_after_write", pixel_out, 12'hFED);
        scan_all();
`else
        fill(24'h112233, 1, 0);
        chk("db_done1", frame_done_out, 1);
        chk("db_full_ready", wr_ready_out, 0);
        nf();
        chk("db_ready_after_nf", wr_ready_out, 1);
        fill(24'h445566, 1, 0);
        nf();
        scan_all();

        fill(24'hFF0000, 0, 0);
        chk("db_done_red", frame_done_out, 1);
        chk("db_ready_low", wr_ready_out, 0);
        wr(10, 5, 24'h000000);
        sc(10, 5, 1);
        idle();
        chk("db_old_bank", pixel_out, 12'h456);
        nf();
        chk("db_ready_back", wr_ready_out, 1);
        sc(10, 5, 1);
        idle();
        chk("db_new_bank", pixel_out, 12'hF00);
        scan_all();

        wr(10, 5, 24'h707070);
        wr(11, 5, 24'h808080);
        aresetn = 1'b0;
        idle();
        idle();
        chk("db_reset_ready", wr_ready_out, 1);
        aresetn = 1'b1;
        sc(10, 5, 1);
        idle();
        chk("db_reset_front0", pixel_out, 12'h777);

        fill(24'h102030, 1, 1);
        chk("db_done_with_nf", frame_done_out, 1);
        sc(10, 5, 1);
        idle();
        chk("db_no_swap_same_cycle", pixel_out, 12'h777);
        nf();
        chk("db_ready_swap", wr_ready_out, 1);
        sc(10, 5, 1);
        idle();
        chk("db_swap_next_nf", pixel_out, 12'h123);
        scan_all();
`endif
        repeat (2) idle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
